lsu: RTL

Load/store unit in the memory-access stage, between the ex_ls pipeline register and the ls_wb register. It converts ex-stage load/store requests into transactions on a req/gnt/rvalid data bus, produces store byte enables and sign/zero-extended load data, and passes ALU results through for non-memory instructions. While a bus access is outstanding it raises a stall request to ctrl, which freezes stages 0–4 and lets writeback drain.

---
 rtl/lsu.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// Load/store unit: turns ex-stage load/store requests into req/gnt/rvalid bus transactions,
// formats store data, extends load data and stalls the pipeline while an access is in flight.
module lsu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  ls_op_i,
   input  logic [31:0] ls_addr_i,
   input  logic [31:0] ls_wdata_i,
   input  logic        rd_we_i,
   input  logic [4:0]  rd_addr_i,
   input  logic [31:0] rd_data_i,
   output logic        rd_we_o,
   output logic [4:0]  rd_addr_o,
   output logic [31:0] rd_data_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        stall_req_o,
   output logic        misalign_o,
   input  logic [5:0]  stall_i,
   input  logic [4:0]  flush_i
);

   localparam logic [3:0] OpLb  = 4'd1;
   localparam logic [3:0] OpLh  = 4'd2;
   localparam logic [3:0] OpLw  = 4'd3;
   localparam logic [3:0] OpLbu = 4'd4;
   localparam logic [3:0] OpLhu = 4'd5;
   localparam logic [3:0] OpSb  = 4'd6;
   localparam logic [3:0] OpSh  = 4'd7;
   localparam logic [3:0] OpSw  = 4'd8;

   typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  op_q, op_d;
   logic [4:0]  rd_addr_q, rd_addr_d;
   logic        rd_we_q, rd_we_d;
   logic        kill_q, kill_d;
   logic        res_we_q, res_we_d;
   logic [4:0]  res_addr_q, res_addr_d;
   logic [31:0] res_data_q, res_data_d;

   logic        ext_stall, flush, kill_now, done;
   logic        in_load, in_store, in_half, in_word, in_misalign;
   logic        store_q;
   logic [3:0]  in_be;
   logic [31:0] in_wdata, shifted, load_data;
   logic        unused_bits;

   assign ext_stall   = stall_i[4];
   assign flush       = flush_i[4];
   assign kill_now    = kill_q | flush;
   assign unused_bits = ^{stall_i[5], stall_i[3:0], flush_i[3:0]};

   assign in_load     = ls_op_i inside {OpLb, OpLh, OpLw, OpLbu, OpLhu};
   assign in_store    = ls_op_i inside {OpSb, OpSh, OpSw};
   assign in_half     = ls_op_i inside {OpLh, OpLhu, OpSh};
   assign in_word     = ls_op_i inside {OpLw, OpSw};
   assign in_misalign = (in_half & ls_addr_i[0]) | (in_word & (|ls_addr_i[1:0]));
   assign store_q     = op_q inside {OpSb, OpSh, OpSw};

   always_comb begin
      in_be    = 4'b1111;
      in_wdata = ls_wdata_i;
      case (ls_op_i)
         OpSb: begin
            in_be    = 4'b0001 << ls_addr_i[1:0];
            in_wdata = {4{ls_wdata_i[7:0]}};
         end
         OpSh: begin
            in_be    = ls_addr_i[1] ? 4'b1100 : 4'b0011;
            in_wdata = {2{ls_wdata_i[15:0]}};
         end
         default: ;
      endcase
   end

   // Byte offset comes from the address latched when the request was issued.
   assign shifted = mem_rdata_i >> {addr_q[1:0], 3'b000};

   always_comb begin
      case (op_q)
         OpLb:    load_data = {{24{shifted[7]}}, shifted[7:0]};
         OpLbu:   load_data = {24'b0, shifted[7:0]};
         OpLh:    load_data = {{16{shifted[15]}}, shifted[15:0]};
         OpLhu:   load_data = {16'b0, shifted[15:0]};
         default: load_data = mem_rdata_i;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      be_d        = be_q;
      wdata_d     = wdata_q;
      op_d        = op_q;
      rd_addr_d   = rd_addr_q;
      rd_we_d     = rd_we_q;
      kill_d      = kill_q;
      res_we_d    = res_we_q;
      res_addr_d  = res_addr_q;
      res_data_d  = res_data_q;
      done        = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = {addr_q[31:2], 2'b00};
      mem_be_o    = be_q;
      mem_wdata_o = wdata_q;
      stall_req_o = 1'b0;
      misalign_o  = 1'b0;
      rd_we_o     = rd_we_i;
      rd_addr_o   = rd_addr_i;
      rd_data_o   = rd_data_i;

      unique case (state_q)
         StIdle: begin
            mem_addr_o  = {ls_addr_i[31:2], 2'b00};
            mem_be_o    = in_be;
            mem_wdata_o = in_wdata;
            if (flush) begin
               // flushed op: no request this cycle
            end else if ((in_load | in_store) & in_misalign) begin
               misalign_o = 1'b1;
               rd_we_o    = 1'b0;
            end else if (in_load | in_store) begin
               mem_req_o = 1'b1;
               mem_we_o  = in_store;
               addr_d    = ls_addr_i;
               be_d      = in_be;
               wdata_d   = in_wdata;
               op_d      = ls_op_i;
               rd_addr_d = rd_addr_i;
               rd_we_d   = rd_we_i;
               if (mem_gnt_i & in_store) begin
                  done = 1'b1;
               end else begin
                  stall_req_o = 1'b1;
                  rd_we_o     = 1'b0;
                  state_d     = mem_gnt_i ? StWait : StReq;
               end
            end
         end
         StReq: begin
            mem_req_o   = 1'b1;
            mem_we_o    = store_q;
            stall_req_o = 1'b1;
            rd_we_o     = 1'b0;
            rd_addr_o   = rd_addr_q;
            if (flush) kill_d = 1'b1;
            if (mem_gnt_i) begin
               if (store_q) begin
                  done        = 1'b1;
                  stall_req_o = 1'b0;
                  rd_we_o     = rd_we_q & ~kill_now;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            stall_req_o = 1'b1;
            rd_we_o     = 1'b0;
            rd_addr_o   = rd_addr_q;
            if (flush) kill_d = 1'b1;
            if (mem_rvalid_i) begin
               done        = 1'b1;
               stall_req_o = 1'b0;
               rd_we_o     = rd_we_q & ~kill_now;
               rd_data_o   = load_data;
            end
         end
         StHold: begin
            rd_we_o   = res_we_q & ~flush;
            rd_addr_o = res_addr_q;
            rd_data_o = res_data_q;
            if (flush | ~ext_stall) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // A later stage is stalled: park the result so the held ex_ls op is not reissued.
      if (done) begin
         if (ext_stall) begin
            state_d    = StHold;
            res_we_d   = rd_we_o;
            res_addr_d = rd_addr_o;
            res_data_d = rd_data_o;
         end else begin
            state_d = StIdle;
         end
      end
      if (state_d == StIdle) kill_d = 1'b0;

      if (!rst_n) begin
         mem_req_o   = 1'b0;
         stall_req_o = 1'b0;
         misalign_o  = 1'b0;
         mem_be_o    = 4'b0;
         mem_wdata_o = 32'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         addr_q     <= 32'b0;
         be_q       <= 4'b0;
         wdata_q    <= 32'b0;
         op_q       <= 4'b0;
         rd_addr_q  <= 5'b0;
         rd_we_q    <= 1'b0;
         kill_q     <= 1'b0;
         res_we_q   <= 1'b0;
         res_addr_q <= 5'b0;
         res_data_q <= 32'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         op_q       <= op_d;
         rd_addr_q  <= rd_addr_d;
         rd_we_q    <= rd_we_d;
         kill_q     <= kill_d;
         res_we_q   <= res_we_d;
         res_addr_q <= res_addr_d;
         res_data_q <= res_data_d;
      end
   end

endmodule
